// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue/collect stage wrapped around alu_32bit.
// Requests are queued in a small FIFO. They are issued one at a time onto the
// ALU operand/opcode inputs. The stage waits out the ALU's one-cycle registered
// latency and returns each result in order.
// Optional feature macro: ALU_OP_CHECK_EN. When it is defined, opcodes above
// 4'b1010 are flagged on res_illegal.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until it is
// accepted. res_valid and res_data do not change while res_valid && !res_ready.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_shift,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  output logic [4:0]       alu_shift,
  input  logic [31:0]      alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_PW = PTR_W + 1;
  localparam logic [PTR_W:0] FULL_CNT = CNT_PW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Each FIFO entry is packed as {a, b, op, shift}.
  logic [72:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [1:0]       state;
  logic             rdy_en;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [72:0]      head;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [3:0]       head_op;
  logic [4:0]       head_shift;

  // rdy_en stays low for one cycle after reset, so in_ready starts at 0.
  assign fifo_empty = (count == '0);
  assign in_ready   = rdy_en && (count != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign pop        = !fifo_empty &&
                      ((state == S_IDLE) || ((state == S_HOLD) && res_ready));
  assign busy       = !fifo_empty || (state != S_IDLE);
  assign dbg_state  = state;

  assign head       = mem[rd_ptr];
  assign head_a     = head[72:41];
  assign head_b     = head[40:9];
  assign head_op    = head[8:5];
  assign head_shift = head[4:0];

  // FIFO storage: write the incoming request at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_op, in_shift};
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue FSM: load the ALU operands, wait for the registered result, then hold it until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rdy_en    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_shift <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      op_count  <= '0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (pop) begin
            {alu_a, alu_b, alu_op, alu_shift} <= {head_a, head_b, head_op, head_shift};
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The ALU samples the operands at the edge that closes this cycle.
          state <= S_WAIT;
        end
        S_WAIT: begin
          res_data  <= alu_out;
          res_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            if (pop) begin
              {alu_a, alu_b, alu_op, alu_shift} <= {head_a, head_b, head_op, head_shift};
              state <= S_ISSUE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_OP_CHECK_EN
  logic op_illegal_q;
  logic res_illegal_q;

  // Flag an undefined opcode when it is popped. Present the flag together with its result and hold it until handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_illegal_q  <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      if (pop) op_illegal_q <= (head_op > 4'b1010);
      if (state == S_WAIT) begin
        res_illegal_q <= op_illegal_q;
      end else if ((state == S_HOLD) && res_ready) begin
        res_illegal_q <= 1'b0;
      end
    end
  end

  assign res_illegal = res_illegal_q;
`else
  assign res_illegal = 1'b0;
`endif

endmodule
